// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lsu_ctrl                                                   |
// | Description : Multi-cycle load/store unit. Accepts one load or store per |
// |               valid/ready handshake and drives a byte-addressed data     |
// |               memory with combinational read data. It returns a sign- or |
// |               zero-extended load result with a one-cycle response pulse. |
// | Option      : `define LSU_MISALIGN_SPLIT_EN to complete misaligned H/W   |
// |               accesses as byte sequences. When it is undefined, those    |
// |               accesses respond with rsp_err and touch no memory.         |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata   |
// |               rsp_valid/rsp_err/rsp_rdata                                |
// |               dm_wr/dm_ctrl/dm_addr/dm_wdata (out), dm_rdata (in)        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        dm_wr,
    output logic [2:0]  dm_ctrl,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] S_SPLIT  = 2'd2;
`endif
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_reject;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  r_k;
    logic [23:0] r_asm;
    logic        w_split_last;
    logic [31:0] w_split_data;
`endif

    // Request classification: only funct3 values that name a real access
    // for the given direction are legal; alignment is judged on the size.
    always_comb begin
        w_illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = req_we;
            default:                w_illegal = 1'b1;
        endcase
        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    assign w_accept = (r_state == S_IDLE) && req_valid;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_reject = w_illegal;
`else
    assign w_reject = w_illegal || w_misaligned;
`endif

`ifdef LSU_MISALIGN_SPLIT_EN
    // Halfword ends after byte 1, word after byte 3.
    assign w_split_last = (r_funct3[1:0] == 2'b01) ? (r_k == 2'd1) : (r_k == 2'd3);

    // Final assembly uses the byte arriving this cycle plus the bytes
    // collected in earlier cycles.
    always_comb begin
        if (r_funct3[1:0] == 2'b01) begin
            w_split_data = {(r_funct3[2] ? 16'h0000 : {16{dm_rdata[7]}}),
                            dm_rdata[7:0], r_asm[7:0]};
        end else begin
            w_split_data = {dm_rdata[7:0], r_asm[23:0]};
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (!req_valid)     w_next = S_IDLE;
                else if (w_reject)  w_next = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                else if (w_misaligned) w_next = S_SPLIT;
`endif
                else                w_next = S_ACCESS;
            end
            S_ACCESS: w_next = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
            S_SPLIT:  w_next = w_split_last ? S_RESP : S_SPLIT;
`endif
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic; memory lines are idle (all zero) outside access states
    // so a reset drops dm_wr without waiting for a clock.
    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_RESP);
        dm_wr     = 1'b0;
        dm_ctrl   = 3'b000;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        case (r_state)
            S_ACCESS: begin
                dm_wr    = r_we;
                dm_ctrl  = r_funct3;
                dm_addr  = r_addr;
                dm_wdata = r_wdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_SPLIT: begin
                dm_wr    = r_we;
                dm_ctrl  = r_we ? 3'b000 : 3'b100;
                dm_addr  = r_addr + {30'd0, r_k};
                case (r_k)
                    2'd0:    dm_wdata = {24'h0, r_wdata[7:0]};
                    2'd1:    dm_wdata = {24'h0, r_wdata[15:8]};
                    2'd2:    dm_wdata = {24'h0, r_wdata[23:16]};
                    default: dm_wdata = {24'h0, r_wdata[31:24]};
                endcase
            end
`endif
            default: ;
        endcase
    end

    // Request latch and response registers. Response fields are written
    // on the edge entering RESP and hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_k       <= 2'd0;
            r_asm     <= 24'h0;
`endif
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                r_k      <= 2'd0;
`endif
                if (w_reject) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
            end
            if (r_state == S_ACCESS) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= r_we ? 32'h0 : dm_rdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_state == S_SPLIT) begin
                r_k <= r_k + 2'd1;
                if (!r_we) begin
                    case (r_k)
                        2'd0:    r_asm[7:0]   <= dm_rdata[7:0];
                        2'd1:    r_asm[15:8]  <= dm_rdata[7:0];
                        default: r_asm[23:16] <= dm_rdata[7:0];
                    endcase
                end
                if (w_split_last) begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_we ? 32'h0 : w_split_data;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lsu_ctrl                                                |
// | Description : Directed self-checking bench for lsu_ctrl with a 256-byte  |
// |               memory model. Split-path checks are built when             |
// |               LSU_MISALIGN_SPLIT_EN is defined, error-path otherwise.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        dm_wr;
    logic [2:0]  dm_ctrl;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .dm_wr(dm_wr), .dm_ctrl(dm_ctrl), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory model, 8-bit address wrap
    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = dm_addr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        case (dm_ctrl)
            3'b000:  dm_rdata = {{24{mem[a0][7]}}, mem[a0]};
            3'b100:  dm_rdata = {24'h0, mem[a0]};
            3'b001:  dm_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b101:  dm_rdata = {16'h0, mem[a1], mem[a0]};
            3'b010:  dm_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
            default: dm_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (dm_wr) begin
            case (dm_ctrl[1:0])
                2'b00: mem[a0] = dm_wdata[7:0];
                2'b01: begin mem[a0] = dm_wdata[7:0]; mem[a1] = dm_wdata[15:8]; end
                2'b10: begin
                    mem[a0] = dm_wdata[7:0];   mem[a1] = dm_wdata[15:8];
                    mem[a2] = dm_wdata[23:16]; mem[a3] = dm_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    int wr_cycles = 0;
    int rsp_pulses = 0;
    always @(negedge clk) begin
        if (dm_wr)     wr_cycles  = wr_cycles + 1;
        if (rsp_valid) rsp_pulses = rsp_pulses + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        assert (got === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction
    int          lat;
    logic        o_err;
    logic [31:0] o_data;
    logic        s_wr;
    logic [2:0]  s_ctrl;
    logic [31:0] s_addr, s_wdata;

    // Issue one request, then count cycles until the response pulse
    // (bounded); snapshot the memory lines in the first post-accept cycle.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int  n;
        logic got;
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        wr_cycles  = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) begin
                s_wr = dm_wr; s_ctrl = dm_ctrl; s_addr = dm_addr; s_wdata = dm_wdata;
            end
            if (rsp_valid) got = 1'b1;
        end
        lat    = got ? n : 99;
        o_err  = rsp_err;
        o_data = rsp_rdata;
    endtask

    function automatic logic [31:0] rd32(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    initial begin
        int p;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready",  {31'h0, req_ready}, 32'h1);
        chk("rst_valid",  {31'h0, rsp_valid}, 32'h0);
        chk("rst_err",    {31'h0, rsp_err},   32'h0);
        chk("rst_rdata",  rsp_rdata,          32'h0);
        chk("rst_dm_wr",  {31'h0, dm_wr},     32'h0);
        chk("rst_dm_ctl", {29'h0, dm_ctrl},   32'h0);
        chk("rst_dm_adr", dm_addr,            32'h0);
        chk("rst_dm_wd",  dm_wdata,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned word store then load
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_lat",   lat, 2);
        chk("sw_err",   {31'h0, o_err}, 32'h0);
        chk("sw_rdata", o_data, 32'h0);
        chk("sw_wr",    {31'h0, s_wr}, 32'h1);
        chk("sw_ctrl",  {29'h0, s_ctrl}, 32'h2);
        chk("sw_addr",  s_addr, 32'h10);
        chk("sw_wdata", s_wdata, 32'hDEADBEEF);
        chk("sw_mem",   rd32(8'h10), 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_pulse_one_cycle", {31'h0, rsp_valid}, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_lat",   lat, 2);
        chk("lw_data",  o_data, 32'hDEADBEEF);
        chk("lw_ctrl",  {29'h0, s_ctrl}, 32'h2);
        chk("lw_nowr",  wr_cycles, 0);

        // Byte loads with sign and zero extension
        mem[8'h20] = 8'h80;
        do_req(1'b0, 3'b000, 32'h20, 32'h0);
        chk("lb_data",  o_data, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h20, 32'h0);
        chk("lbu_data", o_data, 32'h00000080);

        // Aligned halfword store clears the previous load result
        do_req(1'b1, 3'b001, 32'h52, 32'h1234BEEF);
        chk("sh_rdata", o_data, 32'h0);
        chk("sh_ctrl",  {29'h0, s_ctrl}, 32'h1);
        chk("sh_mem",   {16'h0, mem[8'h53], mem[8'h52]}, 32'h0000BEEF);
        chk("sh_mem_untouched", {24'h0, mem[8'h54]}, 32'h0);

        // Aligned halfword loads
        mem[8'h50] = 8'h34; mem[8'h51] = 8'h82;
        do_req(1'b0, 3'b001, 32'h50, 32'h0);
        chk("lh_data",  o_data, 32'hFFFF8234);
        do_req(1'b0, 3'b101, 32'h50, 32'h0);
        chk("lhu_data", o_data, 32'h00008234);

        // Illegal funct3: store 100, load 011
        do_req(1'b1, 3'b100, 32'h60, 32'hFFFFFFFF);
        chk("st100_lat",  lat, 1);
        chk("st100_err",  {31'h0, o_err}, 32'h1);
        chk("st100_rdat", o_data, 32'h0);
        chk("st100_nowr", wr_cycles, 0);
        chk("st100_mem",  rd32(8'h60), 32'h0);
        @(negedge clk);
        chk("err_hold_valid", {31'h0, rsp_valid}, 32'h0);
        chk("err_hold_err",   {31'h0, rsp_err},   32'h1);
        do_req(1'b0, 3'b100, 32'h20, 32'h0);
        chk("err_cleared", {31'h0, o_err}, 32'h0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ld011_lat",  lat, 1);
        chk("ld011_err",  {31'h0, o_err}, 32'h1);
        chk("ld011_rdat", o_data, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Misaligned word store as four byte stores
        do_req(1'b1, 3'b010, 32'h05, 32'h11223344);
        chk("ssw_lat",   lat, 5);
        chk("ssw_err",   {31'h0, o_err}, 32'h0);
        chk("ssw_wrcyc", wr_cycles, 4);
        chk("ssw_ctrl",  {29'h0, s_ctrl}, 32'h0);
        chk("ssw_addr",  s_addr, 32'h05);
        chk("ssw_wdata", s_wdata, 32'h44);
        chk("ssw_mem",   rd32(8'h05), 32'h11223344);
        do_req(1'b0, 3'b010, 32'h05, 32'h0);
        chk("slw_lat",   lat, 5);
        chk("slw_ctrl",  {29'h0, s_ctrl}, 32'h4);
        chk("slw_data",  o_data, 32'h11223344);
        do_req(1'b0, 3'b001, 32'h07, 32'h0);
        chk("slh_lat",   lat, 3);
        chk("slh_data",  o_data, 32'h00001122);
        mem[8'h31] = 8'h80; mem[8'h32] = 8'hFF;
        do_req(1'b0, 3'b001, 32'h31, 32'h0);
        chk("slh_sign",  o_data, 32'hFFFFFF80);
        do_req(1'b0, 3'b101, 32'h31, 32'h0);
        chk("slhu_zero", o_data, 32'h0000FF80);

        // Reset during the third byte of a split store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h41; req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        p = rsp_pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dm_wr", {31'h0, dm_wr}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready",   {31'h0, req_ready}, 32'h1);
        chk("rst_mid_no_rsp",  rsp_pulses - p, 0);
        chk("rst_mid_mem",     rd32(8'h41), 32'h0000CCDD);
`else
        // Misaligned accesses are rejected without touching memory
        do_req(1'b0, 3'b001, 32'h03, 32'h0);
        chk("mlh_lat",   lat, 1);
        chk("mlh_err",   {31'h0, o_err}, 32'h1);
        chk("mlh_rdata", o_data, 32'h0);
        chk("mlh_nowr",  wr_cycles, 0);
        do_req(1'b0, 3'b101, 32'h51, 32'h0);
        chk("mlhu_err",  {31'h0, o_err}, 32'h1);
        do_req(1'b1, 3'b010, 32'h05, 32'h11223344);
        chk("msw_err",   {31'h0, o_err}, 32'h1);
        chk("msw_nowr",  wr_cycles, 0);
        chk("msw_mem",   rd32(8'h04), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
